// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned SEG_W     = 7;
  // Segment bus order is {a,b,c,d,e,f,g}: a sits in the MSB, g in the LSB.
  localparam int unsigned SEG_A_BIT = SEG_W - 1;
  localparam int unsigned SEG_G_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/bcd_to_7_seg.sv
// Combinational nibble to 7-segment decoder, active-high, {a,b,c,d,e,f,g}.
module bcd_to_7_seg
  import seg7_pkg::*;
(
  input  logic [3:0]                 i_bcd,
  output logic [SEG_A_BIT:SEG_G_BIT] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_OFF;
    case (i_bcd)
      4'h0: o_seg_c = 7'b1111110;
      4'h1: o_seg_c = 7'b0110000;
      4'h2: o_seg_c = 7'b1101101;
      4'h3: o_seg_c = 7'b1111001;
      4'h4: o_seg_c = 7'b0110011;
      4'h5: o_seg_c = 7'b1011011;
      4'h6: o_seg_c = 7'b1011111;
      4'h7: o_seg_c = 7'b1110000;
      4'h8: o_seg_c = 7'b1111111;
      4'h9: o_seg_c = 7'b1111011;
      4'hA: o_seg_c = 7'b1110111;
      4'hB: o_seg_c = 7'b0011111;
      4'hC: o_seg_c = 7'b1001110;
      4'hD: o_seg_c = 7'b0111101;
      4'hE: o_seg_c = 7'b1001111;
      4'hF: o_seg_c = 7'b1000111;
      default: o_seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a multi-digit 7-segment display with
// tear-free, frame-synchronous content updates through a valid/ready port.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 1000,
  parameter int unsigned GAP        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  output logic [SEG_W-1:0]        seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pending;
  logic                r_ready;
  logic [DATA_W-1:0]   r_shadow_data;
  logic [NUM_DIGITS-1:0] r_shadow_blank;
  logic [DATA_W-1:0]   r_act_data;
  logic [NUM_DIGITS-1:0] r_act_blank;
  logic [SEG_W-1:0]    r_seg_out;
  logic [NUM_DIGITS-1:0] r_dig_sel;
  logic                r_frame_done;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_boundary;
  logic                w_xfer;
  logic                w_pending_nxt;
  logic [DATA_W-1:0]   w_act_data_nxt;
  logic [NUM_DIGITS-1:0] w_act_blank_nxt;
  logic [3:0]          w_nibble;
  logic                w_blank_bit;
  logic                w_drive;
  logic [SEG_W-1:0]    w_seg_c;

  assign w_idx_inc = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  assign w_xfer    = load_valid && !r_pending;

  // Scan sequencing; the wrap out of the last digit's slot is the frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_boundary  = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DRIVE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        ST_DRIVE: begin
          if (r_cnt == DWELL_END) begin
            w_cnt_nxt = '0;
            if (GAP > 0) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_idx_nxt  = w_idx_inc;
              w_boundary = (r_idx == LAST_IDX);
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_END) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = w_idx_inc;
            w_boundary  = (r_idx == LAST_IDX);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Active contents change only at a boundary, or at once when the display is stopped.
  always_comb begin
    w_act_data_nxt  = r_act_data;
    w_act_blank_nxt = r_act_blank;
    w_pending_nxt   = r_pending;
    if (w_xfer && (w_boundary || !enable)) begin
      w_act_data_nxt  = load_data;
      w_act_blank_nxt = load_blank;
    end else begin
      if (w_boundary && r_pending) begin
        w_act_data_nxt  = r_shadow_data;
        w_act_blank_nxt = r_shadow_blank;
        w_pending_nxt   = 1'b0;
      end
      if (w_xfer) begin
        w_pending_nxt = 1'b1;
      end
    end
  end

  // Outputs are registered from next-cycle values so they line up with the state.
  always_comb begin
    w_nibble    = '0;
    w_blank_bit = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_nibble    = w_act_data_nxt[4*k +: 4];
        w_blank_bit = w_act_blank_nxt[k];
      end
    end
  end

  assign w_drive = (w_state_nxt == ST_DRIVE);

  bcd_to_7_seg u_dec (
    .i_bcd   (w_nibble),
    .o_seg_c (w_seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_pending      <= 1'b0;
      r_ready        <= 1'b1;
      r_shadow_data  <= '0;
      r_shadow_blank <= '0;
      r_act_data     <= '0;
      r_act_blank    <= '1;
      r_seg_out      <= SEG_OFF;
      r_dig_sel      <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_ready      <= !w_pending_nxt;
      r_act_data   <= w_act_data_nxt;
      r_act_blank  <= w_act_blank_nxt;
      r_frame_done <= w_boundary;
      if (w_xfer) begin
        r_shadow_data  <= load_data;
        r_shadow_blank <= load_blank;
      end
      r_dig_sel <= w_drive ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;
      r_seg_out <= (w_drive && !w_blank_bit) ? w_seg_c : SEG_OFF;
    end
  end

  assign load_ready = r_ready;
  assign seg_out    = r_seg_out;
  assign dig_sel    = r_dig_sel;
  assign frame_done = r_frame_done;

endmodule
